bus_demux_1x4: RTL and testbench
================================

# bus_demux_1x4

Routes one initiator's memory-mapped request to one of four targets selected by two address bits, then returns that target's response. It is the fan-out counterpart to the datapath's 4:1 select muxes. It sits between the core's load/store port and the data memory, MMIO, and peripheral regions. It tracks one outstanding transaction through a small FSM and enforces a per-transaction timeout.

## Interface
- WIDTH, 32, data width of wdata/rdata
- ADDR_WIDTH, 32, address width
- SEL_LSB, 28, target select = req_addr[SEL_LSB+1:SEL_LSB]; legal range 0..ADDR_WIDTH-2
- TIMEOUT, 15, max BUSY cycles before error completion; minimum 1

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  initiator request present
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_WIDTH  request address
- req_wdata  in  WIDTH  write data
- req_we  in  1  1 = write, 0 = read
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  WIDTH  read data (0 on writes and errors)
- resp_err  out  1  response is a timeout error
- tgt_valid  out  4  one-hot request to target i
- tgt_addr  out  ADDR_WIDTH  captured address, broadcast
- tgt_wdata  out  WIDTH  captured write data, broadcast
- tgt_we  out  1  captured write enable, broadcast
- tgt_done  in  4  target i completes (one cycle)
- tgt_rdata0..tgt_rdata3  in  WIDTH each  read data of target i, valid with its tgt_done bit

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - A transfer occurs on req_valid & req_ready.
  - On transfer, capture addr, wdata, we, and sel into registers; clear the timeout counter; go to BUSY.
- BUSY:
  - tgt_valid = 1 << sel_q, held until completion. Other bits are 0.
  - tgt_addr, tgt_wdata, and tgt_we show the captured values.
  - Counter increments each BUSY cycle.
  - If tgt_done[sel_q]=1: latch the rdata of target sel_q (forced to 0 if we_q=1), set err=0, go to RESP.
  - Else if counter reaches TIMEOUT-1: latch rdata=0, err=1, go to RESP.
  - A done and a timeout in the same cycle count as done (err=0).
- Non-selected tgt_done bits are ignored in every state.
- tgt_done in IDLE or RESP is ignored.
- RESP: resp_valid=1 for exactly one cycle with the latched rdata and err, then go to IDLE. resp_rdata and resp_err hold until the next RESP.
- Only one transaction is outstanding at a time. req_ready=0 in BUSY and RESP. The initiator must hold req_valid and its payload until the transfer.
- rst:
  - Forces IDLE and clears the counter, captured registers, resp_rdata, and resp_err.
  - Applies from any state. A mid-transaction reset drops the transaction with no response.
  - While rst=1, req_ready=0.

## Timing
- Reset values: req_ready=0 during rst and 1 in the first cycle after rst falls. resp_valid=0, resp_rdata=0, resp_err=0, tgt_valid=0, tgt_addr=0, tgt_wdata=0, tgt_we=0.
- Transfer at edge N: tgt_valid is asserted from cycle N+1.
- tgt_done sampled at edge M: tgt_valid drops and resp_valid=1 in cycle M+1. req_ready=1 in cycle M+2.
- Minimum turnaround (done in the first BUSY cycle) is 3 cycles per transaction.
- Timeout: with no done, resp_valid rises TIMEOUT+1 cycles after the transfer cycle, with err=1. tgt_valid is asserted for exactly TIMEOUT cycles.
- All outputs are registered or decoded only from state and captured registers. There are no combinational paths from inputs to outputs.

## Test plan
- Read target 2: req_addr=0x2000_0010, we=0, tgt_done[2] one cycle after tgt_valid=4'b0100 with tgt_rdata2=0xDEAD_BEEF -> resp_valid for 1 cycle, rdata=0xDEAD_BEEF, err=0, req_ready high 2 cycles after done.
- Write target 0: addr=0x0000_0004, wdata=0x1234_5678, we=1, immediate tgt_done[0] -> tgt_wdata=0x1234_5678 and tgt_we=1 while tgt_valid=4'b0001; rdata=0, err=0.
- Wrong-target done: request to target 3, pulse tgt_done[1] -> ignored, still BUSY. tgt_done[3] later -> normal response.
- Timeout, TIMEOUT=15: request to target 1, no done -> tgt_valid=4'b0010 for 15 cycles, then resp_valid with err=1, rdata=0. A done on the 15th BUSY cycle gives err=0 instead.
- Reset mid-BUSY: assert rst 3 cycles into BUSY -> tgt_valid=0 next cycle, no resp_valid, req_ready=1 the cycle after rst drops. Next read completes normally.
- Back-to-back: req_valid held high for 4 requests, one to each target, with immediate done -> 4 responses spaced 3 cycles apart, correct routing, no dropped or duplicated transfers.

Source files
------------

// File: rtl/bus_demux_1x4.sv
// 1-to-4 request demux: routes one outstanding request to the target picked by
// two address bits, returns its response, and completes with an error on timeout.
module bus_demux_1x4 #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SEL_LSB    = 28,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  input  logic                  req_we,
  output logic                  resp_valid,
  output logic [WIDTH-1:0]      resp_rdata,
  output logic                  resp_err,
  output logic [3:0]            tgt_valid,
  output logic [ADDR_WIDTH-1:0] tgt_addr,
  output logic [WIDTH-1:0]      tgt_wdata,
  output logic                  tgt_we,
  input  logic [3:0]            tgt_done,
  input  logic [WIDTH-1:0]      tgt_rdata0,
  input  logic [WIDTH-1:0]      tgt_rdata1,
  input  logic [WIDTH-1:0]      tgt_rdata2,
  input  logic [WIDTH-1:0]      tgt_rdata3
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [1:0]            r_sel;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_wdata;
  logic                  r_we;
  logic [WIDTH-1:0]      r_rdata;
  logic                  r_err;
  logic                  r_req_ready;

  logic                  w_transfer;
  logic                  w_done_sel;
  logic                  w_timeout;
  logic [WIDTH-1:0]      w_tgt_rdata;
  logic [1:0]            w_next_state;

  // r_req_ready is only ever set while idle, so it doubles as the IDLE qualifier
  assign w_transfer = req_valid & r_req_ready;
  assign w_done_sel = tgt_done[r_sel];
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Read data of the selected target
  always_comb begin
    w_tgt_rdata = {WIDTH{1'b0}};
    case (r_sel)
      2'd0:    w_tgt_rdata = tgt_rdata0;
      2'd1:    w_tgt_rdata = tgt_rdata1;
      2'd2:    w_tgt_rdata = tgt_rdata2;
      2'd3:    w_tgt_rdata = tgt_rdata3;
      default: w_tgt_rdata = {WIDTH{1'b0}};
    endcase
  end

  // Next-state logic for the single-outstanding-transaction FSM
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_transfer) w_next_state = S_BUSY;
        else            w_next_state = S_IDLE;
      end
      S_BUSY: begin
        if (w_done_sel || w_timeout) w_next_state = S_RESP;
        else                         w_next_state = S_BUSY;
      end
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, capture, timeout counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_sel       <= 2'd0;
      r_addr      <= {ADDR_WIDTH{1'b0}};
      r_wdata     <= {WIDTH{1'b0}};
      r_we        <= 1'b0;
      r_rdata     <= {WIDTH{1'b0}};
      r_err       <= 1'b0;
      r_req_ready <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_req_ready <= (w_next_state == S_IDLE);
      if (w_transfer) begin
        r_sel   <= req_addr[SEL_LSB+1:SEL_LSB];
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_we    <= req_we;
        r_cnt   <= {CNT_W{1'b0}};
      end else if (r_state == S_BUSY) begin
        // a done arriving on the timeout cycle still wins
        if (w_done_sel) begin
          r_rdata <= r_we ? {WIDTH{1'b0}} : w_tgt_rdata;
          r_err   <= 1'b0;
        end else if (w_timeout) begin
          r_rdata <= {WIDTH{1'b0}};
          r_err   <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign tgt_valid  = (r_state == S_BUSY) ? (4'b0001 << r_sel) : 4'b0000;
  assign tgt_addr   = r_addr;
  assign tgt_wdata  = r_wdata;
  assign tgt_we     = r_we;

endmodule

// File: tb/tb_bus_demux_1x4.sv
// Self-checking bench for bus_demux_1x4: directed scenarios plus randomized
// transactions checked against a transaction-level expectation model.
module tb_bus_demux_1x4;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [3:0]  tgt_valid;
  logic [31:0] tgt_addr;
  logic [31:0] tgt_wdata;
  logic        tgt_we;
  logic [3:0]  tgt_done;
  logic [31:0] tdata [4];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_resp = -1;

  always #5 clk = ~clk;

  bus_demux_1x4 #(.WIDTH(32), .ADDR_WIDTH(32), .SEL_LSB(28), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .tgt_valid(tgt_valid), .tgt_addr(tgt_addr), .tgt_wdata(tgt_wdata), .tgt_we(tgt_we),
    .tgt_done(tgt_done),
    .tgt_rdata0(tdata[0]), .tgt_rdata1(tdata[1]), .tgt_rdata2(tdata[2]), .tgt_rdata3(tdata[3])
  );

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Random target read data; random done pulses on non-selected targets, one of
  // which (sel+2) always fires so stray dones are certainly exercised.
  task automatic noise(input bit en, input logic [1:0] sel, input bit fire);
    logic [1:0] other;
    for (int i = 0; i < 4; i++) tdata[i] = $urandom;
    other = sel + 2'd2;
    if (en) tgt_done = (4'($urandom) | (4'b0001 << other)) & ~(4'b0001 << sel);
    else    tgt_done = 4'b0000;
    if (fire) tgt_done[sel] = 1'b1;
  endtask

  // One transaction. done_at = BUSY cycle index carrying tgt_done[sel] (-1: never).
  // gap > 0 additionally checks the spacing from the previous response.
  task automatic txn(input logic [31:0] addr, input logic [31:0] wdata, input bit we,
                     input int done_at, input bit ns, input int gap);
    logic [1:0]  sel;
    logic [31:0] exp_rd;
    bit          ok;
    int          busy_len;
    int          w;
    sel      = addr[29:28];
    ok       = (done_at >= 0) && (done_at < TIMEOUT);
    busy_len = ok ? done_at + 1 : TIMEOUT;
    exp_rd   = 32'h0;
    req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_we = we;
    w = 0;
    while (req_ready !== 1'b1 && w < 20) begin
      noise(ns, sel, 1'b0);
      tick;
      w++;
    end
    chk("req_ready_idle", req_ready, 1'b1);
    tick;
    if (gap == 0) begin
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_we = ~we;
    end
    for (int k = 0; k < busy_len; k++) begin
      chk("tgt_valid_busy", tgt_valid, 4'b0001 << sel);
      chk("tgt_addr", tgt_addr, addr);
      chk("tgt_wdata", tgt_wdata, wdata);
      chk("tgt_we", tgt_we, we);
      chk("resp_valid_busy", resp_valid, 1'b0);
      chk("req_ready_busy", req_ready, 1'b0);
      noise(ns, sel, k == done_at);
      if (k == done_at && !we) exp_rd = tdata[sel];
      tick;
    end
    tgt_done = ns ? 4'($urandom) : 4'b0000;
    chk("resp_valid", resp_valid, 1'b1);
    chk("tgt_valid_resp", tgt_valid, 4'b0000);
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_err", resp_err, !ok);
    chk("req_ready_resp", req_ready, 1'b0);
    if (gap > 0 && last_resp >= 0) chk("b2b_gap", cyc - last_resp, gap);
    last_resp = cyc;
    tick;
    tgt_done = 4'b0000;
    chk("resp_valid_drop", resp_valid, 1'b0);
    chk("req_ready_after", req_ready, 1'b1);
    chk("resp_rdata_hold", resp_rdata, exp_rd);
    chk("resp_err_hold", resp_err, !ok);
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_we = 1'b0;
    tgt_done = 4'b0000;
    for (int i = 0; i < 4; i++) tdata[i] = 32'h0;
    tick;
    tick;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_tgt_valid", tgt_valid, 4'b0000);
    chk("rst_tgt_addr", tgt_addr, 32'h0);
    chk("rst_tgt_wdata", tgt_wdata, 32'h0);
    chk("rst_tgt_we", tgt_we, 1'b0);
    rst = 1'b0;
    tick;
    chk("post_rst_ready", req_ready, 1'b1);

    // Directed: read target 2 (done one cycle after tgt_valid rises)
    txn(32'h2000_0010, 32'h0, 1'b0, 1, 1'b0, 0);
    // Directed: write target 0 with immediate done
    txn(32'h0000_0004, 32'h1234_5678, 1'b1, 0, 1'b0, 0);
    // Directed: target 3, stray dones (incl. bit 1) ignored, own done later
    txn(32'h3000_0100, 32'h0, 1'b0, 4, 1'b1, 0);
    // Directed: timeout on target 1, then done on the last BUSY cycle
    txn(32'h1000_0020, 32'h0, 1'b0, -1, 1'b0, 0);
    txn(32'h1000_0024, 32'h0, 1'b0, TIMEOUT - 1, 1'b0, 0);

    // Directed: reset three cycles into BUSY drops the transaction
    req_valid = 1'b1; req_addr = 32'h2000_0040; req_wdata = 32'h0; req_we = 1'b0;
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    chk("pre_rst_tgt_valid", tgt_valid, 4'b0100);
    rst = 1'b1;
    tick;
    chk("mid_rst_tgt_valid", tgt_valid, 4'b0000);
    chk("mid_rst_resp_valid", resp_valid, 1'b0);
    chk("mid_rst_req_ready", req_ready, 1'b0);
    chk("mid_rst_tgt_addr", tgt_addr, 32'h0);
    rst = 1'b0;
    tick;
    chk("after_rst_ready", req_ready, 1'b1);
    chk("after_rst_resp_valid", resp_valid, 1'b0);
    txn(32'h2000_0044, 32'h0, 1'b0, 2, 1'b1, 0);

    // Randomized transactions against the expectation model
    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      txn(a, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, TIMEOUT + 3) - 1, 1'b1, 0);
    end

    // Back-to-back: one request per target, immediate done, 3-cycle spacing
    last_resp = -1;
    for (int t = 0; t < 4; t++) begin
      a = $urandom;
      a[29:28] = 2'(t);
      txn(a, $urandom, 1'($urandom_range(0, 1)), 0, 1'b1, 3);
    end
    req_valid = 1'b0;
    tick;
    chk("idle_after_b2b", tgt_valid, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
